// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix folding.
// Optional odd-parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_key_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keyCode,
  output logic       keyValid,
  output logic       keyBreak,
  output logic       keyExt,
  output logic       frameError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic            clk_s1, clk_s2, clk_s3;
  logic            dat_s1, dat_s2;
  logic            fall;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic [TW-1:0]   tcnt;
  logic            brk_flag, ext_flag;
  logic            frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic            par_bit;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  // Stop bit must be 1; with parity checking the 9 bits must hold an odd count of ones.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = dat_s2 & (^{shift, par_bit});
`else
  assign frame_ok = dat_s2;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      tcnt       <= '0;
      brk_flag   <= 1'b0;
      ext_flag   <= 1'b0;
      keyCode    <= 8'h00;
      keyValid   <= 1'b0;
      keyBreak   <= 1'b0;
      keyExt     <= 1'b0;
      frameError <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      keyValid   <= 1'b0;
      frameError <= 1'b0;

      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift <= {dat_s2, shift[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= dat_s2;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              frameError <= 1'b1;
            end else if (shift == 8'hE0) begin
              ext_flag <= 1'b1;
            end else if (shift == 8'hF0) begin
              brk_flag <= 1'b1;
            end else begin
              keyCode  <= shift;
              keyBreak <= brk_flag;
              keyExt   <= ext_flag;
              keyValid <= 1'b1;
              brk_flag <= 1'b0;
              ext_flag <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TO_MAX) begin
        // Stalled keyboard: drop the partial byte silently, prefix flags survive.
        state   <= IDLE;
        bit_cnt <= 3'd0;
        shift   <= 8'h00;
      end
    end
  end

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Receives scan-code frames from a PS/2 keyboard and turns them into single-cycle key events for the game logic. It synchronises the keyboard's clock and data lines, assembles and checks 11-bit frames, and folds the 0xE0 (extended) and 0xF0 (break) prefixes into the following byte. Its `keyCode`/`keyValid` outputs connect directly to the paddle controller's 8-bit key input and its enable input.

## Interface
- `TIMEOUT_CYCLES`, default 50000: the number of system clocks with no PS/2 falling edge after which a partially received frame is dropped (1 ms at 50 MHz).
- `clock`  in  1  system clock; all logic is on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `PS2_CLK`  in  1  raw keyboard clock pin; asynchronous to `clock`.
- `PS2_DAT`  in  1  raw keyboard data pin; asynchronous to `clock`.
- `keyCode`  out  8  last decoded scan code, with prefixes removed.
- `keyValid`  out  1  one-cycle strobe; `keyCode`, `keyBreak` and `keyExt` are valid in this cycle.
- `keyBreak`  out  1  1 = key release (the byte was preceded by 0xF0).
- `keyExt`  out  1  1 = extended key (0xE0 was seen in the current sequence).
- `frameError`  out  1  one-cycle strobe: bad stop bit, or bad parity (see Configuration).

## Operation
- Input conditioning:
  - `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchroniser.
  - A third register on the clock line gives edge detection; a falling edge is synced-previous = 1 and synced-current = 0.
  - All sampling of data happens on detected falling edges only.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a falling edge, if data = 0 (start bit), go to DATA with bit count 0. If data = 1, stay in IDLE with no error.
  - DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: if data = 1 and parity is OK, hand the byte to the decode stage; otherwise pulse `frameError`. Return to IDLE in both cases.
- Timeout counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - It clears on every falling edge and in IDLE, and counts up in any other state.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial byte is discarded, and no error is raised.
- Decode stage:
  - Byte 0xE0: set the ext flag; no output.
  - Byte 0xF0: set the break flag; no output.
  - Any other byte: load `keyCode` with the byte, `keyBreak` with the break flag and `keyExt` with the ext flag, pulse `keyValid`, then clear both flags.
  - Flags persist across frames until a non-prefix byte arrives; a frame error or timeout does not clear them.
- Reset values: `keyCode` = 0x00; `keyValid`, `keyBreak`, `keyExt`, `frameError` = 0; FSM in IDLE; flags, shift register, bit counter and timeout counter = 0.

## Timing
- A falling edge is detected 3 `clock` cycles after the pin falls (two synchroniser stages plus the edge register).
- `keyValid` or `frameError` is asserted on the cycle after the stop-bit falling edge is detected, and lasts exactly 1 cycle.
- `keyCode`, `keyBreak` and `keyExt` hold their values after the strobe until the next `keyValid`.
- `keyValid` and `frameError` are never asserted in the same cycle.
- Minimum spacing between events is one full PS/2 frame; no back-pressure and no buffering are provided. The consumer must accept the strobe in the same cycle.
- A timeout in the same cycle as a falling edge: the edge wins and the counter clears.
- Asynchronous reset in the middle of a frame: immediate return to reset values. The remainder of that frame on the pins is treated as line noise until a start bit is seen from IDLE.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - Odd parity over the 8 data bits plus the parity bit is required.
  - On a mismatch, `frameError` pulses, no `keyValid` is produced, and the byte does not reach the decode stage.
- Undefined:
  - The parity bit is sampled and ignored.
  - Only a bad stop bit produces `frameError`.

## Test plan
- Frame 0x1C with parity 0 and stop 1, PS/2 clock at 12.5 kHz -> one `keyValid` with `keyCode` = 0x1C, `keyBreak` = 0, `keyExt` = 0; `frameError` stays 0.
- Sequence F0, 1C -> exactly one `keyValid`, with `keyCode` = 0x1C and `keyBreak` = 1. A following 1C gives `keyBreak` = 0.
- Sequence E0, F0, 74 (right-arrow release) -> one `keyValid` with `keyCode` = 0x74, `keyExt` = 1, `keyBreak` = 1.
- 0x1C sent with parity 1:
  - Macro defined -> `frameError` pulses for 1 cycle, no `keyValid`.
  - Macro undefined -> `keyValid` with 0x1C.
- Five bits of a frame, then clock idle for TIMEOUT_CYCLES+10 cycles, then a full frame 0x23 -> no output for the partial frame; `keyValid` with 0x23 for the full frame.
- `resetn` pulsed low after 4 data bits of a frame, then the PS/2 line left idle, then frame 0x1B -> all outputs 0 during and after reset; a single `keyValid` with 0x1B.
